// File: rtl/drec_sdram_arbiter_if.sv
// Signal bundle between the recorder's record/play requesters, the arbiter and
// the SDRAM controller command port. The slave modport is the arbiter's view.
interface drec_sdram_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  mem_ready, mem_rdata_valid, mem_rdata,
    output wr_ack, rd_ack, rd_data, rd_err,
    output mem_valid, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output mem_ready, mem_rdata_valid, mem_rdata,
    input  wr_ack, rd_ack, rd_data, rd_err,
    input  mem_valid, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/drec_sdram_arbiter.sv
// Round-robin arbiter giving the record (write) and play (read) paths turns on
// the single SDRAM command port, one transaction in flight, with read timeout.
module drec_sdram_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int RD_TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 rst,
  drec_sdram_arbiter_if.slave  bus,
  output logic [1:0]           dbg_state
);

  localparam int               TMR_W   = $clog2(RD_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(RD_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

  state_t            state_q, state_d;
  grant_t            last_grant_q;
  logic [TMR_W-1:0]  timer_q;
  logic              valid_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_wr;
  logic              grant_rd;
  logic              mem_hs;

  // Command handshake: a command transfers in a cycle where mem_valid and
  // mem_ready are both high; mem_valid and the command fields stay stable
  // until then and never drop without a transfer (except on reset).
  always_comb begin
    state_d     = state_q;
    grant_wr    = 1'b0;
    grant_rd    = 1'b0;
    mem_hs      = valid_q & bus.mem_ready;
    bus.wr_ack  = 1'b0;
    bus.rd_ack  = 1'b0;
    bus.rd_err  = 1'b0;
    bus.rd_data = '0;
    // Acks are suppressed during reset so an aborted transaction never completes.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.wr_req && (!bus.rd_req || last_grant_q == GNT_RD)) begin
            grant_wr = 1'b1;
            state_d  = WR_ISSUE;
          end else if (bus.rd_req) begin
            grant_rd = 1'b1;
            state_d  = RD_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (mem_hs) begin
            bus.wr_ack = 1'b1;
            state_d    = IDLE;
          end
        end
        RD_ISSUE: begin
          if (mem_hs) state_d = RD_WAIT;
        end
        RD_WAIT: begin
          if (bus.mem_rdata_valid) begin
            bus.rd_ack  = 1'b1;
            bus.rd_data = bus.mem_rdata;
            state_d     = IDLE;
          end else if (timer_q == TMR_MAX) begin
            bus.rd_ack = 1'b1;
            bus.rd_err = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_RD;
      timer_q      <= '0;
      valid_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == WR_ISSUE) || (state_d == RD_ISSUE);
      if (grant_wr) begin
        we_q         <= 1'b1;
        addr_q       <= bus.wr_addr;
        wdata_q      <= bus.wr_data;
        last_grant_q <= GNT_WR;
      end else if (grant_rd) begin
        we_q         <= 1'b0;
        addr_q       <= bus.rd_addr;
        last_grant_q <= GNT_RD;
      end
      // Timer counts cycles spent in RD_WAIT and saturates at the timeout.
      if (state_q == RD_ISSUE && mem_hs) begin
        timer_q <= '0;
      end else if (state_q == RD_WAIT && timer_q != TMR_MAX) begin
        timer_q <= timer_q + TMR_W'(1);
      end
    end
  end

  assign bus.mem_valid = valid_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_drec_sdram_arbiter.sv
// Directed bench for drec_sdram_arbiter: completions are predicted into a queue
// when requests are driven and popped when the arbiter acknowledges them.
module tb_drec_sdram_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int TO = 4;
  localparam int EW = 2 + AW + DW;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  drec_sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  drec_sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Expected completion: {kind, addr, data}; kind 0 = write, 1 = read ok, 2 = read error.
  logic [EW-1:0] exp_q[$];

  int          n_checks;
  int          n_pass;
  int          cyc_n;
  int          ack_cyc;
  int          wr_ack_n;
  int          rd_ack_n;
  bit          auto_mem;
  bit          rd_hs_seen;
  logic [15:0] auto_data;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [1:0] k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({k, a, d});
  endtask

  task automatic mon();
    logic [EW-1:0] e;
    logic [1:0]    obs_kind;
    if (bus.mem_valid && bus.mem_ready && !bus.mem_we && exp_q.size() != 0)
      check("rd_cmd_addr", 48'(bus.mem_addr), 48'(exp_q[0][AW+DW-1:DW]));
    rd_hs_seen = bus.mem_valid && bus.mem_ready && !bus.mem_we;
    if (bus.wr_ack || bus.rd_ack) begin
      ack_cyc = cyc_n;
      check("ack_excl", 48'(bus.wr_ack & bus.rd_ack), 48'(0));
      check("sb_nonempty", 48'(exp_q.size() != 0), 48'(1));
      if (bus.wr_ack) wr_ack_n++;
      if (bus.rd_ack) rd_ack_n++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        obs_kind = bus.wr_ack ? 2'd0 : (bus.rd_err ? 2'd2 : 2'd1);
        check("ack_kind", 48'(obs_kind), 48'(e[EW-1:EW-2]));
        if (bus.wr_ack) begin
          check("wr_mem_we", 48'(bus.mem_we), 48'(1));
          check("wr_mem_addr", 48'(bus.mem_addr), 48'(e[AW+DW-1:DW]));
          check("wr_mem_wdata", 48'(bus.mem_wdata), 48'(e[DW-1:0]));
        end else begin
          check("rd_data", 48'(bus.rd_data), 48'(e[DW-1:0]));
        end
      end
    end
  endtask

  // One clock cycle: settle, observe, then advance to just after the next edge.
  task automatic tick();
    #1;
    mon();
    @(posedge clk);
    cyc_n++;
    #1;
    if (auto_mem) begin
      bus.mem_rdata_valid = rd_hs_seen;
      if (rd_hs_seen) begin
        bus.mem_rdata = auto_data;
        auto_data     = auto_data + 16'd1;
      end
    end
  endtask

  initial begin
    int n0;
    int acks0;
    int r1;
    int w1;
    rst                 = 1'b1;
    bus.wr_req          = 1'b0;
    bus.wr_addr         = '0;
    bus.wr_data         = '0;
    bus.rd_req          = 1'b0;
    bus.rd_addr         = '0;
    bus.mem_ready       = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
    auto_mem            = 1'b0;
    auto_data           = 16'hA000;

    // Reset values
    tick();
    tick();
    check("rst_mem_valid", 48'(bus.mem_valid), 48'(0));
    check("rst_mem_we", 48'(bus.mem_we), 48'(0));
    check("rst_mem_addr", 48'(bus.mem_addr), 48'(0));
    check("rst_mem_wdata", 48'(bus.mem_wdata), 48'(0));
    check("rst_busy", 48'(bus.busy), 48'(0));
    check("rst_state", 48'(dbg_state), 48'(0));
    check("rst_acks", 48'({bus.wr_ack, bus.rd_ack, bus.rd_err}), 48'(0));
    check("rst_rd_data", 48'(bus.rd_data), 48'(0));
    rst = 1'b0;
    tick();

    // Single write
    n0 = cyc_n;
    bus.wr_req = 1'b1; bus.wr_addr = 24'h000010; bus.wr_data = 16'hBEEF; bus.mem_ready = 1'b1;
    push_exp(2'd0, 24'h000010, 16'hBEEF);
    tick();
    check("w1_mem_valid", 48'(bus.mem_valid), 48'(1));
    check("w1_mem_we", 48'(bus.mem_we), 48'(1));
    check("w1_mem_addr", 48'(bus.mem_addr), 48'h000010);
    check("w1_mem_wdata", 48'(bus.mem_wdata), 48'hBEEF);
    check("w1_busy", 48'(bus.busy), 48'(1));
    tick();
    bus.wr_req = 1'b0;
    check("w1_ack_cyc", 48'(ack_cyc), 48'(n0 + 1));
    check("w1_busy_after", 48'(bus.busy), 48'(0));
    check("w1_valid_after", 48'(bus.mem_valid), 48'(0));
    check("w1_ack_count", 48'(wr_ack_n), 48'(1));

    // Read with command stall
    n0 = cyc_n;
    bus.mem_ready = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 24'h000020;
    push_exp(2'd1, 24'h000020, 16'h1234);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("r1_hold_valid", 48'(bus.mem_valid), 48'(1));
      check("r1_hold_we", 48'(bus.mem_we), 48'(0));
      check("r1_hold_addr", 48'(bus.mem_addr), 48'h000020);
      tick();
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 16'h1234;
    tick();
    bus.mem_rdata_valid = 1'b0; bus.rd_req = 1'b0;
    check("r1_ack_cyc", 48'(ack_cyc), 48'(n0 + 6));
    check("r1_ack_count", 48'(rd_ack_n), 48'(1));
    check("r1_busy_after", 48'(bus.busy), 48'(0));

    // Tie with both requests held: W, R, W, R
    n0 = cyc_n;
    auto_mem = 1'b1; bus.mem_ready = 1'b1;
    bus.wr_req = 1'b1; bus.wr_addr = 24'h000100; bus.wr_data = 16'h1111;
    bus.rd_req = 1'b1; bus.rd_addr = 24'h000200;
    push_exp(2'd0, 24'h000100, 16'h1111);
    push_exp(2'd1, 24'h000200, 16'hA000);
    push_exp(2'd0, 24'h000100, 16'h1111);
    push_exp(2'd1, 24'h000200, 16'hA001);
    acks0 = wr_ack_n + rd_ack_n;
    for (int k = 0; k < 40 && (wr_ack_n + rd_ack_n) < acks0 + 4; k++) tick();
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    check("rr_ack_total", 48'(wr_ack_n + rd_ack_n - acks0), 48'(4));
    check("rr_wr_acks", 48'(wr_ack_n), 48'(3));
    check("rr_last_ack_cyc", 48'(ack_cyc), 48'(n0 + 9));
    tick();
    auto_mem = 1'b0; bus.mem_rdata_valid = 1'b0;

    // Read timeout, then a late data strobe that must be ignored
    n0 = cyc_n;
    bus.rd_req = 1'b1; bus.rd_addr = 24'h000030; bus.mem_ready = 1'b1;
    push_exp(2'd2, 24'h000030, 16'h0000);
    for (int i = 0; i < 7; i++) tick();
    bus.rd_req = 1'b0;
    check("to_ack_cyc", 48'(ack_cyc), 48'(n0 + 6));
    r1 = rd_ack_n;
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 16'h5555;
    tick();
    bus.mem_rdata_valid = 1'b0;
    tick();
    check("to_late_no_ack", 48'(rd_ack_n), 48'(r1));
    check("to_late_busy", 48'(bus.busy), 48'(0));

    // Data arriving on the timeout cycle wins
    n0 = cyc_n;
    bus.rd_req = 1'b1; bus.rd_addr = 24'h000040;
    push_exp(2'd1, 24'h000040, 16'h7777);
    for (int i = 0; i < 6; i++) tick();
    bus.mem_rdata_valid = 1'b1; bus.mem_rdata = 16'h7777;
    tick();
    bus.mem_rdata_valid = 1'b0; bus.rd_req = 1'b0;
    check("edge_ack_cyc", 48'(ack_cyc), 48'(n0 + 6));

    // Reset during RD_WAIT, then a tie grants the write first
    bus.rd_req = 1'b1; bus.rd_addr = 24'h000050; bus.mem_ready = 1'b1;
    tick();
    tick();
    r1 = rd_ack_n;
    rst = 1'b1; bus.rd_req = 1'b0;
    tick();
    rst = 1'b0;
    check("mrst_state", 48'(dbg_state), 48'(0));
    check("mrst_busy", 48'(bus.busy), 48'(0));
    check("mrst_mem_valid", 48'(bus.mem_valid), 48'(0));
    check("mrst_mem_we", 48'(bus.mem_we), 48'(0));
    check("mrst_mem_addr", 48'(bus.mem_addr), 48'(0));
    check("mrst_mem_wdata", 48'(bus.mem_wdata), 48'(0));
    check("mrst_no_ack", 48'(rd_ack_n), 48'(r1));
    n0 = cyc_n;
    auto_mem = 1'b1;
    bus.wr_req = 1'b1; bus.wr_addr = 24'h000300; bus.wr_data = 16'h2222;
    bus.rd_req = 1'b1; bus.rd_addr = 24'h000400;
    push_exp(2'd0, 24'h000300, 16'h2222);
    push_exp(2'd1, 24'h000400, auto_data);
    acks0 = wr_ack_n + rd_ack_n;
    for (int k = 0; k < 40 && (wr_ack_n + rd_ack_n) < acks0 + 2; k++) tick();
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    check("mrst_tie_acks", 48'(wr_ack_n + rd_ack_n - acks0), 48'(2));
    check("mrst_tie_last_cyc", 48'(ack_cyc), 48'(n0 + 4));
    tick();
    auto_mem = 1'b0; bus.mem_rdata_valid = 1'b0;

    // Write request dropped right after the grant still completes once
    n0 = cyc_n;
    bus.mem_ready = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 24'h000060; bus.wr_data = 16'hCAFE;
    push_exp(2'd0, 24'h000060, 16'hCAFE);
    tick();
    bus.wr_req = 1'b0; bus.wr_addr = 24'hFFFFFF; bus.wr_data = 16'h0000;
    for (int i = 0; i < 4; i++) tick();
    w1 = wr_ack_n;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check("drop_ack_cyc", 48'(ack_cyc), 48'(n0 + 5));
    tick();
    tick();
    check("drop_ack_once", 48'(wr_ack_n), 48'(w1 + 1));
    check("drop_busy", 48'(bus.busy), 48'(0));

    check("sb_empty", 48'(exp_q.size()), 48'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
